hazard_scheduler: RTL and testbench
===================================

Name: hazard_scheduler

Overview:
- Pipeline control block that sequences the 5-stage MIPS pipeline around the instruction decoder's ID-stage field outputs.
- Each cycle it decides whether the ID-stage instruction advances, stalls on a hazard, or is squashed.
- Hazards handled: load-use, multiply/divide unit (MDU) occupancy, and taken-branch redirect.
- Tracks MDU busy time with an internal countdown and keeps a saturating stall-cycle counter for performance debug.

Parameters:
- MUL_LAT, 4, cycles the MDU is busy after a MULT/MULTU issues.
- DIV_LAT, 16, cycles the MDU is busy after a DIV/DIVU issues.
- CNT_W, 5, width of the MDU countdown; must satisfy 2^CNT_W > max(MUL_LAT, DIV_LAT).
- STAT_W, 16, width of the stall statistics counter.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- id_valid  input  1  ID stage holds a real instruction.
- id_op  input  6  decoder op field.
- id_rs  input  5  decoder rs field.
- id_rt  input  5  decoder rt field.
- id_func  input  6  decoder func field.
- ex_rd  input  5  destination register of the instruction in EX.
- ex_memread  input  1  instruction in EX is a load.
- br_taken  input  1  branch resolved taken in EX this cycle.
- pc_en  output  1  PC register load enable.
- ifid_en  output  1  IF/ID register load enable.
- ifid_flush  output  1  clear IF/ID to a bubble.
- idex_flush  output  1  insert a bubble into ID/EX.
- mdu_busy  output  1  MDU countdown is nonzero.
- action  output  2  this cycle's decision: 0 RUN, 1 LOAD_STALL, 2 MDU_STALL, 3 FLUSH.
- stall_cnt  output  STAT_W  saturating count of hazard-stall cycles.

Behaviour:
- Decode classes (ID, only when id_valid=1):
  - MDU_OP: op=0x00 and func in {0x18, 0x19, 0x1A, 0x1B}.
  - HILO_RD: op=0x00 and func in {0x10, 0x12}.
  - uses_rt: op in {0x00, 0x04, 0x05, 0x2B}.
- load_hz = ex_memread & (ex_rd != 0) & (ex_rd == id_rs | (uses_rt & ex_rd == id_rt)) & id_valid.
- mdu_hz = mdu_busy & (MDU_OP | HILO_RD).
- Action priority, fixed, combinational from current inputs and registered state:
  - FLUSH if br_taken: pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=1. Any ID hazard is ignored because that instruction is wrong-path.
  - LOAD_STALL if load_hz: pc_en=0, ifid_en=0, ifid_flush=0, idex_flush=1.
  - MDU_STALL if mdu_hz: outputs as for LOAD_STALL.
  - RUN otherwise: pc_en=1, ifid_en=1, both flushes 0.
- Load-use costs exactly one stall cycle; the next cycle the load is in MEM and the hazard clears.
- MDU countdown (registered, CNT_W bits):
  - Loads MUL_LAT (func 0x18/0x19) or DIV_LAT (func 0x1A/0x1B) when action=RUN and ID is MDU_OP. The load fires only on issue, never on a stalled or flushed cycle.
  - Otherwise decrements by 1 while nonzero and holds at 0.
  - A load can never coincide with a nonzero count, because MDU_OP stalls while busy.
  - br_taken does not clear the count; the issuing MDU op is already past ID.
  - mdu_busy = (count != 0). HILO_RD stalls until the cycle in which count reads 0.
- stall_cnt increments by 1 on each LOAD_STALL or MDU_STALL cycle and saturates at all-ones (no wrap). FLUSH and RUN cycles do not count.
- Reset, while rst=1 and registered on the edge:
  - count=0, stall_cnt=0.
  - Outputs forced: pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=1, action=FLUSH, mdu_busy=0.
  - Reset mid-MDU-operation abandons the countdown.
- The first cycle after rst deasserts evaluates normally.

Test Plan:
- Load-use: ex_memread=1, ex_rd=8, ID=add with rs=8 -> exactly one cycle of action=1, pc_en=0, idex_flush=1; next cycle RUN; stall_cnt=1.
- No false hazard: ex_memread=1, ex_rd=0, id_rs=0 -> RUN. Also ex_rd=9 with ID=lw (op=0x23) and rt=9 -> RUN, since rt is not a source for lw.
- MULT then MFLO: MULT issues, then MFLO held in ID -> mdu_busy high 4 cycles, MFLO stalls 4 cycles (action=2), issues in cycle 5; stall_cnt=4.
- DIV then DIV back-to-back -> second DIV stalls 16 cycles, then issues and reloads count=16.
- Simultaneous br_taken=1 with load_hz=1 -> action=3, pc_en=1, both flushes 1, stall_cnt unchanged, count not loaded even if ID was MULT.
- Reset at count=7 with stall_cnt=STAT_W all-ones -> next cycle count=0, stall_cnt=0, mdu_busy=0. Saturation check beforehand: with stall_cnt at all-ones, one more stall leaves it unchanged.

Source files
------------

// File: rtl/hazard_if.sv
`default_nettype none
// ============================================================================
// hazard_if
// ID/EX hazard fields into the scheduler and pipeline enables back out.
// Revision: 1.0
// ============================================================================
interface hazard_if #(
    parameter int STAT_W = 16
);
    logic              id_valid;
    logic [5:0]        id_op;
    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic [5:0]        id_func;
    logic [4:0]        ex_rd;
    logic              ex_memread;
    logic              br_taken;
    logic              pc_en;
    logic              ifid_en;
    logic              ifid_flush;
    logic              idex_flush;
    logic              mdu_busy;
    logic [1:0]        action;
    logic [STAT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_op, id_rs, id_rt, id_func, ex_rd, ex_memread, br_taken,
        input  pc_en, ifid_en, ifid_flush, idex_flush, mdu_busy, action, stall_cnt
    );

    modport slave (
        input  id_valid, id_op, id_rs, id_rt, id_func, ex_rd, ex_memread, br_taken,
        output pc_en, ifid_en, ifid_flush, idex_flush, mdu_busy, action, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/hazard_scheduler.sv
`default_nettype none
// ============================================================================
// hazard_scheduler
// Decides per cycle whether the ID-stage instruction runs, stalls or is flushed.
// Revision: 1.0
// ============================================================================
module hazard_scheduler #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 16,
    parameter int CNT_W   = 5,
    parameter int STAT_W  = 16
) (
    input  logic    clk,
    input  logic    rst,
    hazard_if.slave hz_if
);
    localparam logic [1:0] ACT_RUN        = 2'd0;
    localparam logic [1:0] ACT_LOAD_STALL = 2'd1;
    localparam logic [1:0] ACT_MDU_STALL  = 2'd2;
    localparam logic [1:0] ACT_FLUSH      = 2'd3;

    localparam logic [5:0] C_OP_SPECIAL = 6'h00;
    localparam logic [5:0] C_OP_BEQ     = 6'h04;
    localparam logic [5:0] C_OP_BNE     = 6'h05;
    localparam logic [5:0] C_OP_SW      = 6'h2B;
    localparam logic [5:0] C_FN_MFHI    = 6'h10;
    localparam logic [5:0] C_FN_MFLO    = 6'h12;
    localparam logic [5:0] C_FN_MULT    = 6'h18;
    localparam logic [5:0] C_FN_MULTU   = 6'h19;
    localparam logic [5:0] C_FN_DIV     = 6'h1A;
    localparam logic [5:0] C_FN_DIVU    = 6'h1B;

    localparam logic [CNT_W-1:0]  C_MUL_LOAD = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0]  C_DIV_LOAD = CNT_W'(DIV_LAT);
    localparam logic [STAT_W-1:0] C_STAT_MAX = '1;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [STAT_W-1:0] stall_q, stall_d;

    logic       w_special;
    logic       w_mdu_op;
    logic       w_mdu_is_div;
    logic       w_hilo_rd;
    logic       w_uses_rt;
    logic       w_src_match;
    logic       w_load_hz;
    logic       w_mdu_busy;
    logic       w_mdu_hz;
    logic [1:0] w_action;

    logic       w_pc_en;
    logic       w_ifid_en;
    logic       w_ifid_flush;
    logic       w_idex_flush;
    logic       w_busy_out;
    logic [1:0] w_action_out;

    // ID-stage decode classes
    always_comb begin
        w_special    = (hz_if.id_op == C_OP_SPECIAL);
        w_mdu_op     = hz_if.id_valid & w_special &
                       ((hz_if.id_func == C_FN_MULT) | (hz_if.id_func == C_FN_MULTU) |
                        (hz_if.id_func == C_FN_DIV)  | (hz_if.id_func == C_FN_DIVU));
        w_mdu_is_div = (hz_if.id_func == C_FN_DIV) | (hz_if.id_func == C_FN_DIVU);
        w_hilo_rd    = hz_if.id_valid & w_special &
                       ((hz_if.id_func == C_FN_MFHI) | (hz_if.id_func == C_FN_MFLO));
        w_uses_rt    = w_special | (hz_if.id_op == C_OP_BEQ) |
                       (hz_if.id_op == C_OP_BNE) | (hz_if.id_op == C_OP_SW);
    end

    always_comb begin
        w_src_match = (hz_if.ex_rd == hz_if.id_rs) |
                      (w_uses_rt & (hz_if.ex_rd == hz_if.id_rt));
        w_load_hz   = hz_if.id_valid & hz_if.ex_memread &
                      (hz_if.ex_rd != 5'd0) & w_src_match;
        w_mdu_busy  = (cnt_q != '0);
        w_mdu_hz    = w_mdu_busy & (w_mdu_op | w_hilo_rd);
    end

    // A taken branch wins: the ID instruction is wrong-path, so its hazards are moot
    always_comb begin
        w_action = ACT_RUN;
        if (hz_if.br_taken) begin
            w_action = ACT_FLUSH;
        end else if (w_load_hz) begin
            w_action = ACT_LOAD_STALL;
        end else if (w_mdu_hz) begin
            w_action = ACT_MDU_STALL;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if ((w_action == ACT_RUN) && w_mdu_op) begin
            cnt_d = w_mdu_is_div ? C_DIV_LOAD : C_MUL_LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (((w_action == ACT_LOAD_STALL) || (w_action == ACT_MDU_STALL)) &&
            (stall_q != C_STAT_MAX)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            stall_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    // Reset holds the front end frozen and bubbled regardless of ID contents
    always_comb begin
        w_action_out = w_action;
        w_busy_out   = w_mdu_busy;
        w_pc_en      = 1'b1;
        w_ifid_en    = 1'b1;
        w_ifid_flush = 1'b0;
        w_idex_flush = 1'b0;
        case (w_action)
            ACT_FLUSH: begin
                w_ifid_flush = 1'b1;
                w_idex_flush = 1'b1;
            end
            ACT_LOAD_STALL, ACT_MDU_STALL: begin
                w_pc_en      = 1'b0;
                w_ifid_en    = 1'b0;
                w_idex_flush = 1'b1;
            end
            default: begin
                w_pc_en      = 1'b1;
                w_ifid_en    = 1'b1;
            end
        endcase
        if (rst) begin
            w_action_out = ACT_FLUSH;
            w_busy_out   = 1'b0;
            w_pc_en      = 1'b0;
            w_ifid_en    = 1'b0;
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
        end
    end

    assign hz_if.pc_en      = w_pc_en;
    assign hz_if.ifid_en    = w_ifid_en;
    assign hz_if.ifid_flush = w_ifid_flush;
    assign hz_if.idex_flush = w_idex_flush;
    assign hz_if.mdu_busy   = w_busy_out;
    assign hz_if.action     = w_action_out;
    assign hz_if.stall_cnt  = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scheduler.sv
`default_nettype none
// ============================================================================
// tb_hazard_scheduler
// Table vectors, corner sequences and random traffic against a reference model.
// Revision: 1.0
// ============================================================================
module tb_hazard_scheduler;
    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 16;
    localparam int STAT_W  = 16;
    localparam int STAT_MAX = 65535;

    typedef struct packed {
        logic       valid;
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [5:0] func;
        logic [4:0] exrd;
        logic       mr;
        logic       br;
    } in_t;

    typedef struct packed {
        in_t         in;
        logic [1:0]  act;
        logic        busy_after;
        logic [15:0] stall_after;
    } vec_t;

    logic clk;
    logic rst;
    in_t  cur;
    int   m_cnt;
    int   m_stall;
    int   n_cmp;
    int   n_fail;

    hazard_if #(.STAT_W(STAT_W)) bus ();

    hazard_scheduler #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (5),
        .STAT_W  (STAT_W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .hz_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t mk_in(input logic v, input logic [5:0] op, input logic [4:0] rs,
                                  input logic [4:0] rt, input logic [5:0] fn,
                                  input logic [4:0] exrd, input logic mr, input logic br);
        in_t r;
        r.valid = v; r.op = op; r.rs = rs; r.rt = rt; r.func = fn;
        r.exrd = exrd; r.mr = mr; r.br = br;
        return r;
    endfunction

    function automatic vec_t mk_vec(input in_t i, input logic [1:0] a, input logic b,
                                    input logic [15:0] s);
        vec_t r;
        r.in = i; r.act = a; r.busy_after = b; r.stall_after = s;
        return r;
    endfunction

    // Reference rules stated directly from the decode classes and priority list
    function automatic logic [1:0] ref_action(input in_t v, input int cnt);
        bit mdu_op, hilo, uses_rt, load_hz;
        mdu_op  = v.valid && v.op == 6'h00 && v.func >= 6'h18 && v.func <= 6'h1B;
        hilo    = v.valid && v.op == 6'h00 && (v.func == 6'h10 || v.func == 6'h12);
        uses_rt = (v.op == 6'h00 || v.op == 6'h04 || v.op == 6'h05 || v.op == 6'h2B);
        load_hz = v.valid && v.mr && v.exrd != 0 &&
                  (v.exrd == v.rs || (uses_rt && v.exrd == v.rt));
        if (v.br)                           return 2'd3;
        if (load_hz)                        return 2'd1;
        if (cnt > 0 && (mdu_op || hilo))    return 2'd2;
        return 2'd0;
    endfunction

    // {action, pc_en, ifid_en, ifid_flush, idex_flush}
    function automatic logic [5:0] ctl_of(input logic [1:0] a);
        bit stall;
        stall = (a == 2'd1 || a == 2'd2);
        return {a, !stall, !stall, a == 2'd3, a != 2'd0};
    endfunction

    function automatic logic [22:0] ref_vec();
        logic [1:0] a;
        if (rst) return {6'b11_0_0_1_1, 1'b0, 16'(m_stall)};
        a = ref_action(cur, m_cnt);
        return {ctl_of(a), m_cnt > 0, 16'(m_stall)};
    endfunction

    function automatic logic [22:0] dut_vec();
        return {bus.action, bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_flush,
                bus.mdu_busy, bus.stall_cnt};
    endfunction

    task automatic apply(input in_t v);
        cur            = v;
        bus.id_valid   = v.valid;
        bus.id_op      = v.op;
        bus.id_rs      = v.rs;
        bus.id_rt      = v.rt;
        bus.id_func    = v.func;
        bus.ex_rd      = v.exrd;
        bus.ex_memread = v.mr;
        bus.br_taken   = v.br;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        logic [1:0] a;
        @(posedge clk);
        #1;
        if (rst) begin
            m_cnt   = 0;
            m_stall = 0;
        end else begin
            a = ref_action(cur, m_cnt);
            if (a == 2'd0 && cur.valid && cur.op == 6'h00 && cur.func >= 6'h18 && cur.func <= 6'h1B)
                m_cnt = (cur.func == 6'h1A || cur.func == 6'h1B) ? DIV_LAT : MUL_LAT;
            else if (m_cnt > 0)
                m_cnt = m_cnt - 1;
            if ((a == 2'd1 || a == 2'd2) && m_stall < STAT_MAX)
                m_stall = m_stall + 1;
        end
    endtask

    task automatic cyc(input string name, input bit chk);
        @(negedge clk);
        if (chk) check(name, 32'(dut_vec()), 32'(ref_vec()));
        tick();
    endtask

    function automatic in_t rand_in();
        in_t v;
        v.valid = ($urandom_range(0, 9) != 0);
        case ($urandom_range(0, 5))
            0, 1:    v.op = 6'h00;
            2:       v.op = 6'h04;
            3:       v.op = 6'h23;
            4:       v.op = 6'h2B;
            default: v.op = 6'h08;
        endcase
        case ($urandom_range(0, 6))
            0:       v.func = 6'h18;
            1:       v.func = 6'h19;
            2:       v.func = 6'h1A;
            3:       v.func = 6'h1B;
            4:       v.func = 6'h10;
            5:       v.func = 6'h12;
            default: v.func = 6'h20;
        endcase
        v.rs   = 5'($urandom_range(0, 3));
        v.rt   = 5'($urandom_range(0, 3));
        v.exrd = 5'($urandom_range(0, 3));
        v.mr   = ($urandom_range(0, 2) == 0);
        v.br   = ($urandom_range(0, 9) == 0);
        return v;
    endfunction

    vec_t tbl [16];
    in_t  idle, mult_i, mflo_i, div_i, lduse_i;
    int   k;

    initial begin
        n_cmp = 0; n_fail = 0; m_cnt = 0; m_stall = 0;
        idle    = mk_in(0, 6'h00, 0, 0, 6'h00, 0, 0, 0);
        mult_i  = mk_in(1, 6'h00, 1, 2, 6'h18, 0, 0, 0);
        mflo_i  = mk_in(1, 6'h00, 0, 0, 6'h12, 0, 0, 0);
        div_i   = mk_in(1, 6'h00, 1, 2, 6'h1A, 0, 0, 0);
        lduse_i = mk_in(1, 6'h00, 8, 9, 6'h20, 8, 1, 0);

        tbl[0]  = mk_vec(lduse_i,                                 2'd1, 0, 16'd1);
        tbl[1]  = mk_vec(mk_in(1, 6'h00, 0, 3, 6'h20, 0, 1, 0),   2'd0, 0, 16'd0);
        tbl[2]  = mk_vec(mk_in(1, 6'h23, 1, 9, 6'h00, 9, 1, 0),   2'd0, 0, 16'd0);
        tbl[3]  = mk_vec(mk_in(1, 6'h00, 1, 9, 6'h20, 9, 1, 0),   2'd1, 0, 16'd1);
        tbl[4]  = mk_vec(mk_in(1, 6'h2B, 1, 9, 6'h00, 9, 1, 0),   2'd1, 0, 16'd1);
        tbl[5]  = mk_vec(mk_in(1, 6'h04, 1, 9, 6'h00, 9, 1, 0),   2'd1, 0, 16'd1);
        tbl[6]  = mk_vec(mk_in(1, 6'h08, 1, 9, 6'h00, 9, 1, 0),   2'd0, 0, 16'd0);
        tbl[7]  = mk_vec(mk_in(0, 6'h00, 8, 9, 6'h20, 8, 1, 0),   2'd0, 0, 16'd0);
        tbl[8]  = mk_vec(mk_in(1, 6'h00, 8, 9, 6'h20, 8, 0, 0),   2'd0, 0, 16'd0);
        tbl[9]  = mk_vec(mk_in(1, 6'h00, 8, 9, 6'h18, 8, 1, 1),   2'd3, 0, 16'd0);
        tbl[10] = mk_vec(mult_i,                                  2'd0, 1, 16'd0);
        tbl[11] = mk_vec(mk_in(1, 6'h00, 1, 2, 6'h1B, 0, 0, 0),   2'd0, 1, 16'd0);
        tbl[12] = mk_vec(mk_in(1, 6'h00, 0, 0, 6'h10, 0, 0, 0),   2'd0, 0, 16'd0);
        tbl[13] = mk_vec(mk_in(0, 6'h00, 1, 2, 6'h18, 0, 0, 0),   2'd0, 0, 16'd0);
        tbl[14] = mk_vec(mk_in(1, 6'h00, 8, 2, 6'h19, 8, 1, 0),   2'd1, 0, 16'd1);
        tbl[15] = mk_vec(mk_in(1, 6'h00, 1, 2, 6'h20, 0, 0, 1),   2'd3, 0, 16'd0);

        // Reset state with a hazard present on the inputs
        rst = 1'b1;
        apply(lduse_i);
        cyc("reset_forced", 1);
        cyc("reset_forced", 1);

        for (int i = 0; i < 16; i++) begin
            rst = 1'b1;
            apply(idle);
            cyc("tbl_reset", 1);
            rst = 1'b0;
            apply(tbl[i].in);
            @(negedge clk);
            check($sformatf("tbl%0d_ctl", i),
                  32'({bus.action, bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_flush, bus.mdu_busy}),
                  32'({ctl_of(tbl[i].act), 1'b0}));
            tick();
            apply(idle);
            @(negedge clk);
            check($sformatf("tbl%0d_after", i), 32'({bus.mdu_busy, bus.stall_cnt}),
                  32'({tbl[i].busy_after, tbl[i].stall_after}));
            tick();
        end

        // Load-use stalls exactly one cycle, then the load has moved on
        rst = 1'b1; apply(idle); cyc("seq_reset", 1); rst = 1'b0;
        apply(lduse_i);
        cyc("lduse_stall", 1);
        apply(mk_in(1, 6'h00, 8, 9, 6'h20, 3, 0, 0));
        @(negedge clk);
        check("lduse_next_run", 32'(bus.action), 32'd0);
        check("lduse_stall_cnt", 32'(bus.stall_cnt), 32'd1);
        tick();

        // MULT then MFLO held in ID
        rst = 1'b1; apply(idle); cyc("seq_reset", 1); rst = 1'b0;
        apply(mult_i);
        cyc("mult_issue", 1);
        apply(mflo_i);
        for (int i = 0; i < 4; i++) cyc("mflo_stall", 1);
        @(negedge clk);
        check("mflo_issue", 32'({bus.action, bus.mdu_busy}), 32'd0);
        check("mflo_stall_cnt", 32'(bus.stall_cnt), 32'd4);
        tick();

        // DIV followed by DIV
        rst = 1'b1; apply(idle); cyc("seq_reset", 1); rst = 1'b0;
        apply(div_i);
        cyc("div1_issue", 1);
        k = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.action != 2'd2) break;
            k++;
            tick();
        end
        check("div2_stall_cycles", 32'(k), 32'd16);
        check("div2_issue", 32'(bus.action), 32'd0);
        tick();
        apply(idle);
        k = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.mdu_busy) break;
            k++;
            tick();
        end
        check("div2_busy_cycles", 32'(k), 32'd16);
        tick();

        // Random traffic with occasional reset
        rst = 1'b1; apply(idle); cyc("rnd_reset", 1); rst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            apply(rand_in());
            cyc("random", 1);
        end
        rst = 1'b0;

        // Saturate the stall counter, then reset in the middle of a divide
        rst = 1'b1; apply(idle); cyc("sat_reset", 1); rst = 1'b0;
        apply(lduse_i);
        for (int i = 0; i < STAT_MAX; i++) cyc("sat_fill", 0);
        @(negedge clk);
        check("stall_sat_reach", 32'(bus.stall_cnt), 32'hFFFF);
        tick();
        @(negedge clk);
        check("stall_sat_hold", 32'(bus.stall_cnt), 32'hFFFF);
        tick();
        apply(div_i);
        cyc("sat_div_issue", 1);
        apply(idle);
        for (int i = 0; i < 9; i++) cyc("sat_div_count", 1);
        rst = 1'b1;
        cyc("rst_mid_mdu", 1);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_clear", 32'({bus.action, bus.mdu_busy, bus.stall_cnt}), 32'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
